// File: rtl/clock_mode_pkg.sv
// Shared types and default periods for the clock divider family
// and the mode detector that recovers their selection.
package clock_mode_pkg;

  typedef enum logic [1:0] {
    MODE_NONE   = 2'b00,
    MODE_NORMAL = 2'b01,
    MODE_FAST   = 2'b10,
    MODE_SLOW   = 2'b11
  } mode_t;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    MEASURE = 2'd1,
    STALL   = 2'd2
  } state_t;

  localparam int DEF_NORMAL_PERIOD = 8;
  localparam int DEF_FAST_PERIOD   = 4;
  localparam int DEF_SLOW_PERIOD   = 16;
  localparam int DEF_TOL           = 1;
  localparam int DEF_CONFIRM       = 3;
  localparam int DEF_TIMEOUT       = 48;
  localparam int DEF_CNT_W         = 8;

  // True when p lies in [nom-tol, nom+tol]
  function automatic logic in_window(
    input int p,
    input int nom,
    input int tol
  );
    return (p >= nom - tol) && (p <= nom + tol);
  endfunction

endpackage

// File: rtl/clock_mode_detector_classifier.sv
// Combinational period classifier: maps a measured period
// onto FAST, NORMAL or SLOW, or NONE when outside all windows.
module period_classifier
  import clock_mode_pkg::*;
#(
  parameter int NORMAL_PERIOD = DEF_NORMAL_PERIOD,
  parameter int FAST_PERIOD   = DEF_FAST_PERIOD,
  parameter int SLOW_PERIOD   = DEF_SLOW_PERIOD,
  parameter int TOL           = DEF_TOL,
  parameter int CNT_W         = DEF_CNT_W
) (
  input  logic [CNT_W-1:0] i_period,
  output mode_t            o_class
);

  int w_p;

  assign w_p = int'(i_period);

  // FAST is tested first, then NORMAL, then SLOW
  always_comb begin
    o_class = MODE_NONE;
    if (in_window(w_p, FAST_PERIOD, TOL))
      o_class = MODE_FAST;
    else if (in_window(w_p, NORMAL_PERIOD, TOL))
      o_class = MODE_NORMAL;
    else if (in_window(w_p, SLOW_PERIOD, TOL))
      o_class = MODE_SLOW;
  end

endmodule

// File: rtl/clock_mode_detector.sv
// Samples a divided clock as data, measures its period and
// commits a confirmed NORMAL/FAST/SLOW mode, flagging stalls.
module clock_mode_detector
  import clock_mode_pkg::*;
#(
  parameter int NORMAL_PERIOD = DEF_NORMAL_PERIOD,
  parameter int FAST_PERIOD   = DEF_FAST_PERIOD,
  parameter int SLOW_PERIOD   = DEF_SLOW_PERIOD,
  parameter int TOL           = DEF_TOL,
  parameter int CONFIRM       = DEF_CONFIRM,
  parameter int TIMEOUT       = DEF_TIMEOUT,
  parameter int CNT_W         = DEF_CNT_W
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       sense_clock,
  output logic [1:0] mode,
  output logic       mode_valid,
  output logic       mode_changed,
  output logic       error_code_3
);

  localparam int MW = (CONFIRM < 2) ? 1 : $clog2(CONFIRM + 1);
  localparam logic [MW-1:0] CONF_M = MW'(CONFIRM);
  localparam logic [MW-1:0] ONE_M = MW'(1);
  localparam logic [CNT_W-1:0] TO_C = CNT_W'(TIMEOUT);
  localparam logic [CNT_W-1:0] ONE_C = CNT_W'(1);

  logic             r_sense_d;
  logic             w_rise;
  state_t           r_state;
  state_t           w_state_nxt;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_nxt;
  mode_t            r_mode;
  mode_t            w_mode_nxt;
  mode_t            r_cand;
  mode_t            w_cand_nxt;
  logic [MW-1:0]    r_match;
  logic [MW-1:0]    w_match_nxt;
  logic             r_changed;
  logic             w_changed_nxt;
  logic             r_err;
  logic             w_err_nxt;
  mode_t            w_class;

  assign w_rise = sense_clock & ~r_sense_d;

  period_classifier #(
    .NORMAL_PERIOD(NORMAL_PERIOD),
    .FAST_PERIOD  (FAST_PERIOD),
    .SLOW_PERIOD  (SLOW_PERIOD),
    .TOL          (TOL),
    .CNT_W        (CNT_W)
  ) u_classifier (
    .i_period(r_cnt),
    .o_class (w_class)
  );

  // Delay line for rising-edge detection of the sensed clock
  always_ff @(posedge clock) begin
    if (reset)
      r_sense_d <= 1'b0;
    else
      r_sense_d <= sense_clock;
  end

  // FSM state register
  always_ff @(posedge clock) begin
    if (reset)
      r_state <= IDLE;
    else
      r_state <= w_state_nxt;
  end

  // Next state, period counter, confirmation and commit logic
  always_comb begin
    w_state_nxt   = r_state;
    w_cnt_nxt     = r_cnt;
    w_mode_nxt    = r_mode;
    w_cand_nxt    = r_cand;
    w_match_nxt   = r_match;
    w_changed_nxt = 1'b0;
    w_err_nxt     = r_err;
    unique case (r_state)
      IDLE: begin
        if (w_rise) begin
          w_state_nxt = MEASURE;
          w_cnt_nxt   = ONE_C;
        end
      end
      MEASURE: begin
        if (w_rise) begin
          w_cnt_nxt = ONE_C;
          if (w_class == r_cand) begin
            if (r_match != CONF_M)
              w_match_nxt = r_match + ONE_M;
          end else begin
            w_cand_nxt  = w_class;
            w_match_nxt = ONE_M;
          end
          if (w_match_nxt == CONF_M &&
              w_cand_nxt != r_mode) begin
            w_mode_nxt    = w_cand_nxt;
            w_changed_nxt = 1'b1;
            w_err_nxt     = (w_cand_nxt == MODE_NONE);
          end
        end else if (r_cnt == TO_C) begin
          w_state_nxt   = STALL;
          w_cnt_nxt     = '0;
          w_mode_nxt    = MODE_NONE;
          w_cand_nxt    = MODE_NONE;
          w_match_nxt   = '0;
          w_err_nxt     = 1'b1;
          w_changed_nxt = (r_mode != MODE_NONE);
        end else if (r_cnt != '1) begin
          w_cnt_nxt = r_cnt + ONE_C;
        end
      end
      STALL: begin
        if (w_rise) begin
          w_state_nxt = MEASURE;
          w_cnt_nxt   = ONE_C;
        end
      end
      default: begin
        w_state_nxt = IDLE;
        w_cnt_nxt   = '0;
      end
    endcase
  end

  // Datapath and registered outputs
  always_ff @(posedge clock) begin
    if (reset) begin
      r_cnt     <= '0;
      r_mode    <= MODE_NONE;
      r_cand    <= MODE_NONE;
      r_match   <= '0;
      r_changed <= 1'b0;
      r_err     <= 1'b0;
    end else begin
      r_cnt     <= w_cnt_nxt;
      r_mode    <= w_mode_nxt;
      r_cand    <= w_cand_nxt;
      r_match   <= w_match_nxt;
      r_changed <= w_changed_nxt;
      r_err     <= w_err_nxt;
    end
  end

  assign mode         = r_mode;
  assign mode_valid   = (r_mode != MODE_NONE);
  assign mode_changed = r_changed;
  assign error_code_3 = r_err;

endmodule

// File: tb/tb_clock_mode_detector.sv
// Directed bench for clock_mode_detector: table of waveform
// segments plus hand-written latency, reset and timeout cases.
module tb_clock_mode_detector;

  logic       clock = 1'b0;
  logic       reset;
  logic       sense_clock;
  logic [1:0] mode;
  logic       mode_valid;
  logic       mode_changed;
  logic       error_code_3;

  int errors = 0;
  int checks = 0;
  int pulses = 0;

  // per = 0 means hold sense_clock low for n cycles;
  // otherwise n periods of length per (half high).
  typedef struct {
    int per;
    int n;
    int em;
    int ev;
    int ee;
    int ep;
  } seg_t;

  seg_t segs[16];

  clock_mode_detector dut (
    .clock       (clock),
    .reset       (reset),
    .sense_clock (sense_clock),
    .mode        (mode),
    .mode_valid  (mode_valid),
    .mode_changed(mode_changed),
    .error_code_3(error_code_3)
  );

  always #5 clock = ~clock;

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    end
  endtask

  task automatic tick(input logic s);
    sense_clock = s;
    @(posedge clock);
    #1;
    if (mode_changed) pulses++;
  endtask

  task automatic drive_per(input int per, input int n);
    for (int r = 0; r < n; r++)
      for (int k = 0; k < per; k++)
        tick(k < per / 2);
  endtask

  task automatic run_seg(input int idx);
    pulses = 0;
    if (segs[idx].per == 0) begin
      for (int c = 0; c < segs[idx].n; c++) tick(1'b0);
    end else begin
      drive_per(segs[idx].per, segs[idx].n);
    end
    chk($sformatf("seg%0d mode", idx), int'(mode), segs[idx].em);
    chk($sformatf("seg%0d valid", idx), int'(mode_valid), segs[idx].ev);
    chk($sformatf("seg%0d err", idx), int'(error_code_3), segs[idx].ee);
    chk($sformatf("seg%0d pulses", idx), pulses, segs[idx].ep);
  endtask

  initial begin
    segs[0]  = '{8,  3,  0, 0, 0, 0};
    segs[1]  = '{8,  1,  1, 1, 0, 1};
    segs[2]  = '{4,  3,  1, 1, 0, 0};
    segs[3]  = '{4,  1,  2, 1, 0, 1};
    segs[4]  = '{8,  4,  1, 1, 0, 1};
    segs[5]  = '{9,  1,  1, 1, 0, 0};
    segs[6]  = '{7,  1,  1, 1, 0, 0};
    segs[7]  = '{8,  1,  1, 1, 0, 0};
    segs[8]  = '{4,  1,  1, 1, 0, 0};
    segs[9]  = '{8,  3,  1, 1, 0, 0};
    segs[10] = '{12, 4,  0, 0, 1, 1};
    segs[11] = '{8,  4,  1, 1, 0, 1};
    segs[12] = '{0,  48, 0, 0, 1, 1};
    segs[13] = '{16, 4,  3, 1, 0, 1};
    segs[14] = '{0,  60, 0, 0, 1, 1};
    segs[15] = '{0,  10, 0, 0, 1, 0};

    reset = 1'b1;
    sense_clock = 1'b0;
    tick(1'b0);
    tick(1'b0);
    reset = 1'b0;
    chk("reset mode", int'(mode), 0);
    chk("reset valid", int'(mode_valid), 0);
    chk("reset changed", int'(mode_changed), 0);
    chk("reset err", int'(error_code_3), 0);

    for (int i = 0; i < 16; i++) run_seg(i);

    // Reset mid-acquisition while error_code_3 is high
    drive_per(4, 3);
    reset = 1'b1;
    tick(1'b0);
    reset = 1'b0;
    chk("midreset mode", int'(mode), 0);
    chk("midreset valid", int'(mode_valid), 0);
    chk("midreset changed", int'(mode_changed), 0);
    chk("midreset err", int'(error_code_3), 0);

    // Fresh first edge plus two periods: not yet committed
    drive_per(4, 3);
    chk("reacq pending", int'(mode), 0);
    tick(1'b1);
    chk("reacq mode", int'(mode), 2);
    chk("reacq changed", int'(mode_changed), 1);
    chk("reacq valid", int'(mode_valid), 1);
    chk("reacq err", int'(error_code_3), 0);
    tick(1'b0);
    chk("reacq pulse width", int'(mode_changed), 0);
    chk("reacq hold", int'(mode), 2);
    tick(1'b0);
    tick(1'b0);

    // Edge arriving exactly at the timeout count wins
    pulses = 0;
    tick(1'b1);
    for (int c = 0; c < 47; c++) tick(1'b0);
    tick(1'b1);
    chk("edge wins mode", int'(mode), 2);
    chk("edge wins err", int'(error_code_3), 0);
    chk("edge wins pulses", pulses, 0);

    // Stall fires exactly TIMEOUT cycles after the last edge
    for (int c = 0; c < 47; c++) tick(1'b0);
    chk("pre stall mode", int'(mode), 2);
    tick(1'b0);
    chk("stall mode", int'(mode), 0);
    chk("stall changed", int'(mode_changed), 1);
    chk("stall err", int'(error_code_3), 1);
    chk("stall valid", int'(mode_valid), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
